// File: rtl/dcf77_decoder_pkg.sv
// dcf77_decoder_pkg: BCD type, telegram bit positions and decoder states for the DCF77 decoder
package dcf77_decoder_pkg;
  typedef logic [3:0] bcd_t;
  typedef enum logic [1:0] {HUNT, PULSE, GAP} dcf77_state_t;
  localparam int START_BIT = 0;
  localparam int TIME_START_BIT = 20;
  localparam int MINUTE_LSB = 21;
  localparam int P1_BIT = 28;
  localparam int HOUR_LSB = 29;
  localparam int P2_BIT = 35;
  localparam int DAY_LSB = 36;
  localparam int DOW_LSB = 42;
  localparam int MONTH_LSB = 45;
  localparam int YEAR_LSB = 50;
  localparam int P3_BIT = 58;
  localparam int TELEGRAM_BITS = 59;
  localparam int MAX_BITS = 60;
  function automatic logic digit_ok(input bcd_t d);
    return d <= 4'd9;
  endfunction
endpackage

// File: rtl/dcf77_pulse_meter.sv
// dcf77_pulse_meter: rx synchronizer, optional DCF77_GLITCH_FILTER_EN 3-tap majority filter, pulse/gap timing and edge events
module dcf77_pulse_meter #(
  parameter int TICKS_ZERO_MIN = 5,
  parameter int TICKS_ONE_MIN = 15,
  parameter int TICKS_ONE_MAX = 25,
  parameter int TICKS_GAP_MIN = 150,
  parameter int TICKS_LOST = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic rx,
  output logic rise,
  output logic bit_valid,
  output logic bit_value,
  output logic bit_error,
  output logic minute_mark,
  output logic lost
);
  localparam logic [4:0] ZERO_MIN = 5'(TICKS_ZERO_MIN);
  localparam logic [4:0] ONE_MIN = 5'(TICKS_ONE_MIN);
  localparam logic [4:0] ONE_MAX = 5'(TICKS_ONE_MAX);
  localparam logic [7:0] GAP_MIN = 8'(TICKS_GAP_MIN);
  localparam logic [7:0] LOST_AT = 8'(TICKS_LOST - 1);
  logic [1:0] sync_q;
  logic lvl, prev_q, fall;
  logic [4:0] high_q;
  logic [7:0] low_q;
  always_ff @(posedge clk)
    sync_q <= !rst_n ? 2'b00 : {sync_q[0], rx};
`ifdef DCF77_GLITCH_FILTER_EN
  logic [2:0] tap_q;
  always_ff @(posedge clk)
    if (!rst_n) tap_q <= '0;
    else if (clk_en) tap_q <= {tap_q[1:0], sync_q[1]};
  assign lvl = (tap_q[0] & tap_q[1]) | (tap_q[0] & tap_q[2]) | (tap_q[1] & tap_q[2]);
`else
  assign lvl = sync_q[1];
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      prev_q <= 1'b0;
      high_q <= '0;
      low_q <= '0;
    end else if (clk_en) begin
      prev_q <= lvl;
      high_q <= !lvl ? 5'd0 : !prev_q ? 5'd1 : high_q + {4'd0, high_q != 5'd31};
      low_q <= lvl ? 8'd0 : prev_q ? 8'd1 : low_q + {7'd0, low_q != 8'd255};
    end
  assign rise = clk_en && lvl && !prev_q;
  assign fall = clk_en && !lvl && prev_q;
  assign minute_mark = rise && low_q >= GAP_MIN;
  assign bit_valid = fall && high_q >= ZERO_MIN && high_q <= ONE_MAX;
  assign bit_error = fall && !(high_q >= ZERO_MIN && high_q <= ONE_MAX);
  assign bit_value = high_q >= ONE_MIN;
  assign lost = clk_en && !lvl && !prev_q && low_q == LOST_AT;
endmodule

// File: rtl/dcf77_decoder.sv
// dcf77_decoder: DCF77 telegram decoder with parity/plausibility checks and minute sync (DCF77_GLITCH_FILTER_EN enables rx majority filter)
module dcf77_decoder
  import dcf77_decoder_pkg::*;
#(
  parameter int TICKS_ZERO_MIN = 5,
  parameter int TICKS_ONE_MIN = 15,
  parameter int TICKS_ONE_MAX = 25,
  parameter int TICKS_GAP_MIN = 150,
  parameter int TICKS_LOST = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       rx,
  output logic       dcf77_sync,
  output bcd_t [1:0] dcf77_year,
  output bcd_t [1:0] dcf77_month,
  output bcd_t [1:0] dcf77_day,
  output bcd_t [1:0] dcf77_hour,
  output bcd_t [1:0] dcf77_minute,
  output logic [2:0] dcf77_day_of_week,
  output logic [5:0] second_count,
  output logic       error
);
  dcf77_state_t state_q;
  logic [TELEGRAM_BITS-1:0] buf_q;
  logic [5:0] cnt_q;
  logic err_q, sync_q;
  bcd_t [1:0] year_q, month_q, day_q, hour_q, minute_q;
  logic [2:0] dow_q;
  bcd_t [1:0] year_d, month_d, day_d, hour_d, minute_d;
  logic [2:0] dow_d;
  logic rise, bit_valid, bit_value, bit_error, minute_mark, lost, accept;
  dcf77_pulse_meter #(
    .TICKS_ZERO_MIN(TICKS_ZERO_MIN),
    .TICKS_ONE_MIN(TICKS_ONE_MIN),
    .TICKS_ONE_MAX(TICKS_ONE_MAX),
    .TICKS_GAP_MIN(TICKS_GAP_MIN),
    .TICKS_LOST(TICKS_LOST)
  ) meter (
    .clk(clk),
    .rst_n(rst_n),
    .clk_en(clk_en),
    .rx(rx),
    .rise(rise),
    .bit_valid(bit_valid),
    .bit_value(bit_value),
    .bit_error(bit_error),
    .minute_mark(minute_mark),
    .lost(lost)
  );
  assign minute_d = {{1'b0, buf_q[MINUTE_LSB+4 +: 3]}, buf_q[MINUTE_LSB +: 4]};
  assign hour_d = {{2'b0, buf_q[HOUR_LSB+4 +: 2]}, buf_q[HOUR_LSB +: 4]};
  assign day_d = {{2'b0, buf_q[DAY_LSB+4 +: 2]}, buf_q[DAY_LSB +: 4]};
  assign dow_d = buf_q[DOW_LSB +: 3];
  assign month_d = {{3'b0, buf_q[MONTH_LSB+4]}, buf_q[MONTH_LSB +: 4]};
  assign year_d = {buf_q[YEAR_LSB+4 +: 4], buf_q[YEAR_LSB +: 4]};
  assign accept = cnt_q == 6'(TELEGRAM_BITS) && !err_q
    && !buf_q[START_BIT] && buf_q[TIME_START_BIT]
    && !(^buf_q[P1_BIT:MINUTE_LSB]) && !(^buf_q[P2_BIT:HOUR_LSB]) && !(^buf_q[P3_BIT:DAY_LSB])
    && digit_ok(minute_d[0]) && minute_d[1] <= 4'd5
    && digit_ok(hour_d[0]) && (hour_d[1] < 4'd2 || (hour_d[1] == 4'd2 && hour_d[0] <= 4'd3))
    && digit_ok(day_d[0]) && day_d != '0 && (day_d[1] < 4'd3 || day_d[0] <= 4'd1)
    && digit_ok(month_d[0]) && month_d != '0 && (month_d[1] == 4'd0 || month_d[0] <= 4'd2)
    && dow_d != 3'd0 && digit_ok(year_d[0]) && digit_ok(year_d[1]);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= HUNT;
      buf_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      sync_q <= 1'b0;
      year_q <= '0;
      month_q <= 8'h01;
      day_q <= 8'h01;
      hour_q <= '0;
      minute_q <= '0;
      dow_q <= 3'd1;
    end else if (clk_en) begin
      sync_q <= 1'b0;
      case (state_q)
        HUNT: if (minute_mark) begin
          cnt_q <= '0;
          err_q <= 1'b0;
          state_q <= PULSE;
        end
        PULSE: if (bit_valid || bit_error) begin
          state_q <= GAP;
          if (bit_error) err_q <= 1'b1;
          else begin
            buf_q <= {bit_value, buf_q[TELEGRAM_BITS-1:1]};
            cnt_q <= cnt_q + {5'd0, cnt_q != 6'(MAX_BITS)};
          end
        end
        GAP: if (lost) begin
          err_q <= 1'b1;
          state_q <= HUNT;
        end else if (rise) begin
          state_q <= PULSE;
          if (minute_mark) begin
            cnt_q <= '0;
            err_q <= 1'b0;
            sync_q <= accept;
            if (accept) begin
              year_q <= year_d;
              month_q <= month_d;
              day_q <= day_d;
              hour_q <= hour_d;
              minute_q <= minute_d;
              dow_q <= dow_d;
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  assign dcf77_sync = sync_q;
  assign dcf77_year = year_q;
  assign dcf77_month = month_q;
  assign dcf77_day = day_q;
  assign dcf77_hour = hour_q;
  assign dcf77_minute = minute_q;
  assign dcf77_day_of_week = dow_q;
  assign second_count = cnt_q;
  assign error = err_q;
endmodule

// File: tb/tb_dcf77_decoder.sv
// tb_dcf77_decoder: directed telegram scenarios for dcf77_decoder with assertion-based checking
module tb_dcf77_decoder;
  import dcf77_decoder_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;
  logic rx = 1'b0;
  logic dcf77_sync, error, sync_prev = 1'b0;
  bcd_t [1:0] year, month, day, hour, minute;
  logic [2:0] dow;
  logic [5:0] sec;
  int checks = 0, fails = 0, tick_n = 0, rise_tick = 0, sync_tick = 0, pulses = 0, sync_hi = 0;
  int exp_lat;
  logic [59:0] t1, t1_bad, t2, t3;
  dcf77_decoder dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_en(clk_en),
    .rx(rx),
    .dcf77_sync(dcf77_sync),
    .dcf77_year(year),
    .dcf77_month(month),
    .dcf77_day(day),
    .dcf77_hour(hour),
    .dcf77_minute(minute),
    .dcf77_day_of_week(dow),
    .second_count(sec),
    .error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) clk_en <= ~clk_en;
  always @(posedge clk) if (clk_en) tick_n <= tick_n + 1;
  always @(negedge clk) begin
    sync_prev <= dcf77_sync;
    if (dcf77_sync) sync_hi <= sync_hi + 1;
    if (dcf77_sync && !sync_prev) begin
      pulses <= pulses + 1;
      sync_tick <= tick_n;
    end
  end
  function automatic logic [59:0] tg(input int mi, input int hr, input int dy, input int dw, input int mo, input int yr);
    logic [59:0] b;
    b = '0;
    b[20] = 1'b1;
    b[24:21] = 4'(mi % 10);
    b[27:25] = 3'(mi / 10);
    b[28] = ^b[27:21];
    b[32:29] = 4'(hr % 10);
    b[34:33] = 2'(hr / 10);
    b[35] = ^b[34:29];
    b[39:36] = 4'(dy % 10);
    b[41:40] = 2'(dy / 10);
    b[44:42] = 3'(dw);
    b[48:45] = 4'(mo % 10);
    b[49] = 1'(mo / 10);
    b[53:50] = 4'(yr % 10);
    b[57:54] = 4'(yr / 10);
    b[58] = ^b[57:36];
    return b;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    do @(posedge clk); while (!clk_en);
  endtask
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) tick();
    #1;
  endtask
  task automatic bits(input logic [59:0] t, input int n, input int long_i, input int spike_i);
    for (int i = 1; i < n; i++) begin
      hold(1'b1, i == long_i ? 30 : t[i] ? 20 : 10);
      if (i == spike_i) begin
        hold(1'b0, 5);
        hold(1'b1, 1);
        hold(1'b0, 14);
      end else hold(1'b0, i == n - 1 ? 190 : 20);
    end
  endtask
  task automatic mark();
    rise_tick = tick_n;
    hold(1'b1, 10);
    hold(1'b0, 20);
  endtask
  initial begin
`ifdef DCF77_GLITCH_FILTER_EN
    exp_lat = 4;
`else
    exp_lat = 2;
`endif
    t1 = tg(59, 23, 29, 4, 2, 24);
    t1_bad = t1;
    t1_bad[28] = ~t1_bad[28];
    t2 = tg(0, 0, 1, 5, 3, 24);
    t3 = tg(34, 12, 31, 3, 12, 25);
    repeat (4) tick();
    #1;
    check("rst_sync", 32'(dcf77_sync), 0);
    check("rst_year", 32'(year), 32'h00);
    check("rst_month", 32'(month), 32'h01);
    check("rst_day", 32'(day), 32'h01);
    check("rst_hour", 32'(hour), 32'h00);
    check("rst_min", 32'(minute), 32'h00);
    check("rst_dow", 32'(dow), 1);
    check("rst_sec", 32'(sec), 0);
    check("rst_err", 32'(error), 0);
    rst_n = 1'b1;
    hold(1'b0, 190);
    mark();
    check("hunt_nosync", pulses, 0);
    check("hunt_sec", 32'(sec), 1);
    bits(t1, 59, -1, -1);
    check("t1_sec", 32'(sec), 59);
    check("t1_err", 32'(error), 0);
    mark();
    check("t1_pulses", pulses, 1);
    check("t1_width", sync_hi, 2);
    check("t1_latency", sync_tick - rise_tick, exp_lat);
    check("t1_year", 32'(year), 32'h24);
    check("t1_month", 32'(month), 32'h02);
    check("t1_day", 32'(day), 32'h29);
    check("t1_dow", 32'(dow), 4);
    check("t1_hour", 32'(hour), 32'h23);
    check("t1_min", 32'(minute), 32'h59);
    check("t1_err_after", 32'(error), 0);
    bits(t1_bad, 59, -1, -1);
    mark();
    check("parity_nosync", pulses, 1);
    check("parity_min", 32'(minute), 32'h59);
    bits(t2, 59, -1, -1);
    mark();
    check("t2_pulses", pulses, 2);
    check("t2_month", 32'(month), 32'h03);
    check("t2_day", 32'(day), 32'h01);
    check("t2_dow", 32'(dow), 5);
    check("t2_hour", 32'(hour), 32'h00);
    check("t2_min", 32'(minute), 32'h00);
    bits(t3, 60, -1, -1);
    check("leap_sec", 32'(sec), 60);
    mark();
    check("leap_nosync", pulses, 2);
    check("leap_day", 32'(day), 32'h01);
    bits(t3, 59, -1, -1);
    mark();
    check("t3_pulses", pulses, 3);
    check("t3_year", 32'(year), 32'h25);
    check("t3_month", 32'(month), 32'h12);
    check("t3_day", 32'(day), 32'h31);
    check("t3_dow", 32'(dow), 3);
    check("t3_hour", 32'(hour), 32'h12);
    check("t3_min", 32'(minute), 32'h34);
    bits(t2, 59, 30, -1);
    check("long_err", 32'(error), 1);
    mark();
    check("long_nosync", pulses, 3);
    check("long_err_clr", 32'(error), 0);
    bits(t1, 59, -1, -1);
    hold(1'b0, 70);
    check("lost_err", 32'(error), 1);
    check("lost_sec", 32'(sec), 59);
    mark();
    check("lost_nosync", pulses, 3);
    check("lost_sec_mark", 32'(sec), 1);
    check("lost_err_clr", 32'(error), 0);
    bits(t1, 59, -1, -1);
    mark();
    check("relock_pulses", pulses, 4);
    check("relock_min", 32'(minute), 32'h59);
    check("relock_day", 32'(day), 32'h29);
    bits(t2, 59, -1, 10);
`ifdef DCF77_GLITCH_FILTER_EN
    check("spike_err", 32'(error), 0);
    mark();
    check("spike_pulses", pulses, 5);
    check("spike_width", sync_hi, 10);
`else
    check("spike_err", 32'(error), 1);
    mark();
    check("spike_pulses", pulses, 4);
    check("spike_width", sync_hi, 8);
`endif
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/dcf77_decoder.md
Name: dcf77_decoder

Overview:
- Upstream stage of the DCF77-synchronized clock. Receives the demodulated DCF77 receiver signal and decodes pulse widths into telegram bits.
- Accumulates the 59-bit minute telegram, then checks it with parity and plausibility rules.
- At the start of each new minute, presents the decoded BCD date/time to the clock stage and raises a one-tick dcf77_sync.

Parameters:
- TICKS_ZERO_MIN, 5: minimum high ticks (10 ms each) for a valid pulse; 5..TICKS_ONE_MIN-1 decodes as 0.
- TICKS_ONE_MIN, 15: minimum high ticks for a 1.
- TICKS_ONE_MAX, 25: maximum high ticks for a 1; longer pulses are errors.
- TICKS_GAP_MIN, 150: low ticks at or above which a rising edge is the minute mark.
- TICKS_LOST, 250: low ticks at which the signal is declared lost.

Ports:
- clk  in  1  clock, 24 MHz
- rst_n  in  1  reset, synchronous, active-low
- clk_en  in  1  10 ms tick enable
- rx  in  1  DCF77 receiver output, asynchronous; high = carrier reduced
- dcf77_sync  out  1  high for exactly one clk_en period at minute start
- dcf77_year, dcf77_month, dcf77_day, dcf77_hour, dcf77_minute  out  bcd_t [1:0]  decoded BCD fields
- dcf77_day_of_week  out  3  1 = Monday .. 7 = Sunday
- second_count  out  6  bits received in the current minute, 0..60
- error  out  1  sticky fault in the current minute; cleared at each minute mark

Behaviour:
- Interface (already decided): one clock clk; reset rst_n is synchronous and active-low.
- rx input path: 2-FF synchronizer running on every clk. All remaining logic updates only on clk_en cycles.
- Reset values: all regs 0 except dcf77_month = 01, dcf77_day = 01, dcf77_day_of_week = 1. Reset while in any state returns to HUNT and clears the bit buffer.
- Counters: high_cnt is 5 bits, saturating at 31. low_cnt is 8 bits, saturating at 255. Both clear on the opposite edge.
- HUNT state:
  - Wait for the first rising edge with low_cnt >= TICKS_GAP_MIN.
  - No sync is issued on that edge. Set bit_count = 0 and error = 0, then go to PULSE.
- PULSE state: count high ticks. On the falling edge:
  - high_cnt < TICKS_ZERO_MIN or > TICKS_ONE_MAX: set error.
  - Otherwise store bit[bit_count] (0 if high_cnt < TICKS_ONE_MIN, else 1) and increment bit_count, saturating at 60.
  - In all cases go to GAP.
- GAP state: count low ticks.
  - Rising edge with low_cnt < TICKS_GAP_MIN: go to PULSE.
  - Rising edge with low_cnt >= TICKS_GAP_MIN (minute mark): evaluate the telegram, then clear bit_count and error and go to PULSE.
  - low_cnt reaching TICKS_LOST: set error, go to HUNT.
- Telegram accepted only if all of the following hold:
  - bit_count == 59 (leap-second minutes with 60 bits are rejected) and error == 0.
  - bit0 == 0 and bit20 == 1.
  - Even parity: P1 over bits 21-28, P2 over 29-35, P3 over 36-58.
  - Every BCD digit <= 9; minute < 60; hour < 24; day 1..31; month 1..12; day_of_week 1..7.
- Field layout, LSB first:
  - minute: units 21-24, tens 25-27
  - hour: units 29-32, tens 33-34
  - day: units 36-39, tens 40-41
  - day_of_week: 42-44
  - month: units 45-48, tens 49
  - year: units 50-53, tens 54-57
  - Tens digits are zero-extended to bcd_t.
- On accept:
  - Field outputs and dcf77_sync = 1 are registered on the clk_en cycle where the rising edge is sampled.
  - dcf77_sync drops on the next clk_en cycle, so the clock stage samples it exactly once.
  - Fields hold until the next accept.
- On reject: no sync; fields unchanged.
- second_count mirrors bit_count.

Optional Feature:
- Macro DCF77_GLITCH_FILTER_EN.
- Defined: a 3-tap majority filter on the synchronized rx, sampled on clk_en, feeds the edge logic. This adds 2 ticks (20 ms) of latency to every edge, including the sync.
- Undefined: the synchronized rx is used directly; single-tick spikes reach the decoder.

Decomposition:
- Package types (existing): bcd_t. Add localparam bit positions (MINUTE_LSB, P1_BIT, P2_BIT, P3_BIT, etc.) and the decoder state enum dcf77_state_t {HUNT, PULSE, GAP}.
- One sub-module: dcf77_pulse_meter. It holds the synchronizer, the optional filter, the high/low counters and edge detection, and outputs bit_valid, bit_value, bit_error, minute_mark, lost.
- Telegram buffer, checks and output registers stay in dcf77_decoder.

Test Plan:
- Full valid telegram for 2024-02-29 Thu 23:59, then a 1.9 s gap -> one dcf77_sync pulse of one clk_en period; fields 24/02/29, dow 4, hour 23, minute 59; error 0.
- Same telegram with bit 28 flipped -> no sync, fields keep previous values, next minute decodes normally.
- 60-bit leap-second minute -> no sync; following 59-bit minute accepted.
- 300 ms pulse inside a minute -> error = 1, no sync at the mark, error cleared after the mark.
- rx held low for 2.6 s -> error, second_count returns to 0 at the next mark, HUNT; the first mark after that gives no sync, the second does.
- With DCF77_GLITCH_FILTER_EN: a 10 ms spike in a gap is ignored and sync is delayed exactly 2 ticks. Without the macro: the same spike sets error.
